// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the single-port RAM arbiter: default RAM geometry,
// core address width and the read-return tag carried down the pipeline.
package mem_arbiter_pkg;

    // Default RAM geometry: 32K words of 16 bits.
    localparam int ADDR_W_DEF  = 15;
    localparam int DATA_W_DEF  = 16;

    // The core presents a wider word address; upper bits alias onto the RAM.
    localparam int CORE_ADDR_W = 24;

    // Identifies which requester (if any) owns the read data in flight.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CORE = 2'd1,
        TAG_VGA  = 2'd2
    } rd_tag_t;

    // Tag to launch for a granted access: VGA is always a read, core only
    // when not writing. Writes return nothing, so they carry TAG_NONE.
    function automatic rd_tag_t issue_tag(input logic grant_core,
                                          input logic grant_vga,
                                          input logic core_we);
        rd_tag_t tag;
        tag = TAG_NONE;
        if (grant_vga) begin
            tag = TAG_VGA;
        end else if (grant_core && !core_we) begin
            tag = TAG_CORE;
        end
        return tag;
    endfunction

endpackage

// File: rtl/mem_arbiter_rd_pipe.sv
// Read-return pipeline for mem_arbiter. A tag enters alongside the registered
// RAM command (stage 1), advances to line up with ram_rdata (stage 2), and the
// data is then latched into the owning requester's result register with a
// one-cycle rvalid pulse. Result registers hold between reads.
module mem_arbiter_rd_pipe
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              rst_n,
    input  rd_tag_t           tag_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata
);

    rd_tag_t tag_s1;
    rd_tag_t tag_s2;

    // Advance the tag: stage 1 matches the RAM command, stage 2 matches rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_s1 <= TAG_NONE;
            tag_s2 <= TAG_NONE;
        end else begin
            tag_s1 <= tag_in;
            tag_s2 <= tag_s1;
        end
    end

    // Capture core read data and pulse core_rvalid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
        end else begin
            core_rvalid <= (tag_s2 == TAG_CORE);
            if (tag_s2 == TAG_CORE) begin
                core_rdata <= ram_rdata;
            end
        end
    end

    // Capture VGA read data and pulse vga_rvalid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_rvalid <= 1'b0;
            vga_rdata  <= '0;
        end else begin
            vga_rvalid <= (tag_s2 == TAG_VGA);
            if (tag_s2 == TAG_VGA) begin
                vga_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU core and the VGA scan-out fetcher.
// VGA has fixed priority. Defining MEM_ARBITER_STARVE_GUARD_EN adds a
// starvation guard that forces a core grant after STARVE_LIMIT consecutive
// VGA grants while the core is waiting. The granted command is registered
// onto ram_*; read data comes back through mem_arbiter_rd_pipe.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   core_req,
    input  logic                   core_we,
    input  logic [CORE_ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0]      core_wdata,
    output logic                   core_ack,
    output logic                   core_rvalid,
    output logic [DATA_W-1:0]      core_rdata,
    input  logic                   vga_req,
    input  logic [ADDR_W-1:0]      vga_addr,
    output logic                   vga_ack,
    output logic                   vga_rvalid,
    output logic [DATA_W-1:0]      vga_rdata,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic [DATA_W-1:0]      ram_rdata
);

    logic    grant_core;
    logic    grant_vga;
    logic    force_core;
    rd_tag_t tag_issue;

    // Upper core address bits alias onto the RAM and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^core_addr[CORE_ADDR_W-1:ADDR_W];

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    // Once the core has watched STARVE_LIMIT VGA grants go by, it wins next.
    assign force_core = core_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Count VGA grants taken while the core waits; any core grant or idle core clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!core_req || grant_core) begin
            starve_cnt <= '0;
        end else if (grant_vga) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    // Strict VGA priority: the core is never forced ahead.
    assign force_core = 1'b0;
`endif

    // Grant decision for this cycle: VGA first unless the guard overrides.
    always_comb begin
        grant_vga  = vga_req && !force_core;
        grant_core = core_req && !grant_vga;
        tag_issue  = issue_tag(grant_core, grant_vga, core_we);
    end

    assign core_ack = grant_core;
    assign vga_ack  = grant_vga;

    // Register the granted command onto the RAM port; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (grant_vga) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= vga_addr;
        end else if (grant_core) begin
            ram_en    <= 1'b1;
            ram_we    <= core_we;
            ram_addr  <= core_addr[ADDR_W-1:0];
            ram_wdata <= core_wdata;
        end else begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end
    end

    mem_arbiter_rd_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .tag_in      (tag_issue),
        .ram_rdata   (ram_rdata),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural synchronous 32Kx16 RAM.
// A vector table covers single-cycle grant decisions; hand-written sequences
// cover read latency, back-to-back reads, address aliasing, contention and
// reset during an in-flight read.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req;
    logic        core_we;
    logic [23:0] core_addr;
    logic [15:0] core_wdata;
    logic        core_ack;
    logic        core_rvalid;
    logic [15:0] core_rdata;
    logic        vga_req;
    logic [14:0] vga_addr;
    logic        vga_ack;
    logic        vga_rvalid;
    logic [15:0] vga_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0000;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_ack    (core_ack),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .vga_req     (vga_req),
        .vga_addr    (vga_addr),
        .vga_ack     (vga_ack),
        .vga_rvalid  (vga_rvalid),
        .vga_rdata   (vga_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Synchronous single-port RAM model with registered read.
    logic [15:0] mem [0:32767];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    typedef struct {
        logic        creq;
        logic        cwe;
        logic [23:0] caddr;
        logic [15:0] cwdata;
        logic        vreq;
        logic [14:0] vaddr;
        logic        exp_core_ack;
        logic        exp_vga_ack;
        logic        exp_ram_en;
        logic        exp_ram_we;
        logic [14:0] exp_ram_addr;
    } vec_t;

    vec_t vec [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_c;
        logic exp_v;

        // ---------------- stimulus table ----------------
        //          creq cwe  caddr        cwdata    vreq vaddr     cack vack en   we   addr
        vec[0] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0000};
        vec[1] = '{1'b1, 1'b1, 24'h000123, 16'h5555, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 15'h0123};
        vec[2] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b1, 15'h0456, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0456};
        vec[3] = '{1'b1, 1'b1, 24'h000007, 16'h7777, 1'b1, 15'h0789, 1'b0, 1'b1, 1'b1, 1'b0, 15'h0789};
        vec[4] = '{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 15'h0789};
        vec[5] = '{1'b1, 1'b0, 24'hABCDEF, 16'h0000, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 15'h4DEF};
        vec[6] = '{1'b1, 1'b1, 24'h018200, 16'h0F0F, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 15'h0200};

        rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_addr = '0;
        core_wdata = '0; vga_req = 1'b0; vga_addr = '0;

        // ---------------- reset state ----------------
        #1;
        check("reset core_ack", core_ack, 0);
        check("reset vga_ack", vga_ack, 0);
        check("reset core_rvalid", core_rvalid, 0);
        check("reset vga_rvalid", vga_rvalid, 0);
        check("reset core_rdata", core_rdata, 0);
        check("reset vga_rdata", vga_rdata, 0);
        check("reset ram_en", ram_en, 0);
        check("reset ram_we", ram_we, 0);
        check("reset ram_addr", ram_addr, 0);
        check("reset ram_wdata", ram_wdata, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // ---------------- table-driven grant vectors ----------------
        for (int i = 0; i < 7; i++) begin
            core_req = vec[i].creq; core_we = vec[i].cwe; core_addr = vec[i].caddr;
            core_wdata = vec[i].cwdata; vga_req = vec[i].vreq; vga_addr = vec[i].vaddr;
            #1;
            check($sformatf("vec%0d core_ack", i), core_ack, vec[i].exp_core_ack);
            check($sformatf("vec%0d vga_ack", i), vga_ack, vec[i].exp_vga_ack);
            cyc();
            check($sformatf("vec%0d ram_en", i), ram_en, vec[i].exp_ram_en);
            check($sformatf("vec%0d ram_we", i), ram_we, vec[i].exp_ram_we);
            check($sformatf("vec%0d ram_addr", i), ram_addr, vec[i].exp_ram_addr);
        end
        core_req = 1'b0; vga_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc();

        // ---------------- core write then read-after-write ----------------
        core_req = 1'b1; core_we = 1'b1; core_addr = 24'h000010; core_wdata = 16'h1234;
        #1;
        check("wr ack", core_ack, 1);
        cyc();
        check("wr ram_en", ram_en, 1);
        check("wr ram_we", ram_we, 1);
        check("wr ram_addr", ram_addr, 15'h0010);
        check("wr ram_wdata", ram_wdata, 16'h1234);
        core_we = 1'b0;
        #1;
        check("rd ack", core_ack, 1);
        cyc();
        check("rd ram_en", ram_en, 1);
        check("rd ram_we", ram_we, 0);
        check("rd rvalid n+1", core_rvalid, 0);
        core_req = 1'b0;
        cyc();
        check("rd rvalid n+2", core_rvalid, 0);
        cyc();
        check("rd rvalid n+3", core_rvalid, 1);
        check("rd rdata", core_rdata, 16'h1234);
        cyc();
        check("rd rvalid n+4", core_rvalid, 0);
        check("rd rdata held", core_rdata, 16'h1234);

        // ---------------- back-to-back core writes (preload) ----------------
        for (int k = 0; k < 5; k++) begin
            core_req = 1'b1; core_we = 1'b1;
            core_addr  = (k < 4) ? 24'(k) : 24'h007FFF;
            core_wdata = (k < 4) ? 16'(16'hA0 + k) : 16'hBEEF;
            #1;
            check($sformatf("preload%0d ack", k), core_ack, 1);
            cyc();
        end
        core_req = 1'b0;
        cyc();

        // ---------------- back-to-back VGA reads ----------------
        for (int c = 0; c < 8; c++) begin
            int t;
            if (c < 4) begin
                vga_req = 1'b1; vga_addr = 15'(c);
                #1;
                check($sformatf("vga%0d ack", c), vga_ack, 1);
            end else begin
                vga_req = 1'b0;
            end
            cyc();
            t = c + 1;
            check($sformatf("vga t%0d rvalid", t), vga_rvalid, (t >= 3 && t <= 6) ? 1 : 0);
            if (t >= 3 && t <= 6)
                check($sformatf("vga t%0d rdata", t), vga_rdata, 32'(16'hA0 + t - 3));
        end

        // ---------------- aliased core address ----------------
        core_req = 1'b1; core_we = 1'b0; core_addr = 24'hFFFFFF;
        #1;
        check("alias ack", core_ack, 1);
        cyc();
        check("alias ram_addr", ram_addr, 15'h7FFF);
        check("alias ram_en", ram_en, 1);
        core_req = 1'b0;
        cyc(); cyc();
        check("alias rvalid", core_rvalid, 1);
        check("alias rdata", core_rdata, 16'hBEEF);
        cyc();

        // ---------------- sustained contention ----------------
        core_req = 1'b1; core_we = 1'b0; core_addr = 24'h000010;
        vga_req = 1'b1; vga_addr = 15'h0002;
        for (int c = 0; c < 10; c++) begin
`ifdef MEM_ARBITER_STARVE_GUARD_EN
            exp_c = ((c % 5) == 4);
`else
            exp_c = 1'b0;
`endif
            exp_v = !exp_c;
            #1;
            check($sformatf("contend%0d core_ack", c), core_ack, exp_c);
            check($sformatf("contend%0d vga_ack", c), vga_ack, exp_v);
            cyc();
        end
        core_req = 1'b0; vga_req = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        check("contend vga_rdata", vga_rdata, 16'h00A2);

        // ---------------- reset with a VGA read in flight ----------------
        vga_req = 1'b1; vga_addr = 15'h0001;
        #1;
        check("rst vga ack", vga_ack, 1);
        cyc();
        vga_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst ram_en", ram_en, 0);
        check("rst vga_rdata", vga_rdata, 0);
        check("rst core_rdata", core_rdata, 0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("post-rst%0d vga_rvalid", i), vga_rvalid, 0);
            check($sformatf("post-rst%0d vga_rdata", i), vga_rdata, 0);
            check($sformatf("post-rst%0d ram_en", i), ram_en, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter that shares one synchronous 32K×16 block RAM port between the CPU core and the VGA scan-out fetcher. Each cycle it selects one requester, drives a registered RAM command, and returns read data through a tagged two-stage return pipeline. VGA has fixed priority; an optional starvation guard bounds core wait time. It replaces the dual-port RAM wrapper in the memory controller wherever only a single-port RAM is available.

## Interface
Parameters:
- STARVE_LIMIT, 4, consecutive VGA grants tolerated while core_req is held (guard builds only)
- ADDR_W, 15, RAM address width
- DATA_W, 16, RAM data width

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- core_req  in  1  core access request, level, held until core_ack
- core_we  in  1  1 = write, 0 = read; sampled with core_req
- core_addr  in  24  core byte-free word address; bits [23:15] ignored (alias)
- core_wdata  in  16  write data
- core_ack  out  1  combinational pulse: core access accepted this cycle
- core_rvalid  out  1  registered pulse: core_rdata holds new read data
- core_rdata  out  16  last core read result, held between reads
- vga_req  in  1  VGA read request, level, held until vga_ack
- vga_addr  in  15  VGA word address
- vga_ack  out  1  combinational pulse: VGA read accepted this cycle
- vga_rvalid  out  1  registered pulse: vga_rdata holds new data
- vga_rdata  out  16  last VGA read result, held
- ram_en  out  1  registered RAM enable
- ram_we  out  1  registered RAM write enable
- ram_addr  out  15  registered RAM address
- ram_wdata  out  16  registered RAM write data
- ram_rdata  in  16  RAM read data, valid one cycle after ram_en read

## Operation
- Grant decision in cycle N from current requests: vga_req wins unless guard forces core; else core_req; else none.
- Exactly one of core_ack/vga_ack high when any request present; never both.
- Granted command registered onto ram_* at end of N (valid during N+1). No grant: ram_en=0, ram_we=0, other ram_* hold.
- Return pipeline: tag {NONE, CORE, VGA} travels with reads; stage 1 aligns with ram_* (N+1), stage 2 with ram_rdata (N+2). At end of N+2 ram_rdata is captured into the tagged requester's rdata register; its rvalid is high during N+3 only.
- Core writes: ack, RAM write in N+1, tag NONE, no rvalid.
- Requester may present a new request in N+1 after ack; throughput one access per cycle.
- Same-cycle core_req and vga_req: VGA granted (absent guard override); core_ack stays 0.

## Timing
- Reset values: core_ack/vga_ack 0 (no requests), core_rvalid/vga_rvalid 0, core_rdata/vga_rdata 0, ram_en/ram_we 0, ram_addr/ram_wdata 0, tags NONE, starve counter 0.
- Read latency: ack in N -> rvalid in N+3.
- Write latency: ack in N -> RAM written at end of N+1.
- Reset asserted mid-operation: in-flight tags cleared; no rvalid after rst_n deasserts; rdata registers return to 0.
- Read-after-write same address, core write ack N, read ack N+1: read returns new data (RAM write precedes read in port order).

## Configuration
- MEM_ARBITER_STARVE_GUARD_EN defined: counter increments on each VGA grant while core_req=1, clears on any core grant or when core_req=0; when counter = STARVE_LIMIT, next contended cycle grants core, counter clears. Core wait bounded by STARVE_LIMIT+1 cycles.
- Undefined: strict VGA priority, no counter; core may starve indefinitely; STARVE_LIMIT unused.

## Structure
- Package mem_arbiter_pkg: ADDR_W/DATA_W defaults, tag enum rd_tag_t {TAG_NONE, TAG_CORE, TAG_VGA}.
- Sub-module mem_arbiter_rd_pipe: two-stage tag pipeline, rdata capture registers, rvalid generation.
- Top holds grant logic, starvation counter, RAM command registers.

## Test plan
- Core write 0x1234 to 0x0010, then core read 0x0010 -> ack each cycle, core_rvalid 3 cycles after read ack, core_rdata=0x1234.
- vga_req and core_req both held, guard off -> vga_ack every cycle, core_ack never.
- Same with guard on, STARVE_LIMIT=4 -> 4 vga_acks, 1 core_ack, repeat; counter clears.
- Back-to-back VGA reads 0x0000..0x0003 preloaded 0xA0..0xA3 -> four consecutive vga_rvalid pulses, data in order.
- Core read of 0x7FFF with core_addr[23:15]=0x1FF -> RAM address 0x7FFF.
- rst_n low one cycle after a VGA read ack -> no vga_rvalid, vga_rdata=0, ram_en=0.
